// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction loader
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int LEN_BYTES = 2;
    localparam logic [7:0] CSUM_INIT = 8'h00;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: packs accepted bytes big-endian into 32-bit words, pulsing word_ready on the 4th byte
module word_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  cnt;
    logic [23:0] shift;

    // The 4th byte completes the word combinationally so the top can register it on the same edge
    assign word       = {shift, data};
    assign word_ready = accept && (cnt == 2'd3);

    // Byte counter wraps every word; the shifter always holds the last three bytes seen
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt   <= 2'd0;
            shift <= 24'd0;
        end else if (accept) begin
            cnt   <= cnt + 2'd1;
            shift <= {shift[15:0], data};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed, XOR-checksummed image into instruction memory and releases CPU reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        done,
    output logic        error
);

    state_t              state;
    state_t              next;
    logic [15:0]         len;
    logic [15:0]         len_n;
    logic [7:0]          csum;
    logic [ADDR_W-1:0]   word_index;
    logic                accept;
    logic                start_load;
    logic                last_byte;
    logic                word_ready;
    logic [31:0]         word;

    assign in_ready   = state inside {LEN_HI, LEN_LO, DATA, CHECK};
    assign accept     = in_valid && in_ready;
    assign start_load = start && (state inside {IDLE, DONE, ERROR});
    assign len_n      = {len[15:8], in_data};
    assign last_byte  = word_ready && (16'(word_index) == len - 16'd1);

    word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_load),
        .accept     (accept && (state == DATA)),
        .data       (in_data),
        .word       (word),
        .word_ready (word_ready)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    // Next-state logic: length check on LEN_LO, checksum compare on CHECK
    always_comb begin
        next = state;
        case (state)
            IDLE, DONE, ERROR: next = start ? LEN_HI : state;
            LEN_HI:            next = accept ? LEN_LO : state;
            LEN_LO:            next = !accept                      ? state :
                                      (32'(len_n) > MAX_WORDS)     ? ERROR :
                                      (len_n == 16'd0)             ? CHECK : DATA;
            DATA:              next = last_byte ? CHECK : state;
            CHECK:             next = !accept ? state : (in_data == csum) ? DONE : ERROR;
            default:           next = IDLE;
        endcase
    end

    // Length capture, running checksum over everything but the checksum byte, word index advance
    always_ff @(posedge clk) begin
        if (reset || start_load) begin
            len        <= 16'd0;
            csum       <= CSUM_INIT;
            word_index <= '0;
        end else begin
            if (accept && state == LEN_HI)
                len[15:8] <= in_data;
            if (accept && state == LEN_LO)
                len <= len_n;
            if (accept && state inside {LEN_HI, LEN_LO, DATA})
                csum <= csum_step(csum, in_data);
            if (word_ready)
                word_index <= word_index + 1'b1;
        end
    end

    // Registered outputs; status flags follow the state being entered so they line up with it
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we   <= word_ready;
            cpu_reset <= next != DONE;
            done      <= next == DONE;
            error     <= next == ERROR;
            if (word_ready) begin
                imem_addr  <= 32'({word_index, 2'b00});
                imem_wdata <= word;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of image loading, checksum, length bounds, backpressure and reset
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        done;
    logic        error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;
    wr_t log_q[$];

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we === 1'b1)
            log_q.push_back('{imem_addr, imem_wdata, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic noise(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_nominal_payload();
        send(8'h00); send(8'h02);
        send(8'h20); send(8'h08); send(8'h00); send(8'h05);
        send(8'h01); send(8'h09); send(8'h50); send(8'h20);
    endtask

    initial begin
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);

        noise(6);
        check("idle_no_consume", 32'(log_q.size()), 32'd0);
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Nominal: XOR of 00 02 20 08 00 05 01 09 50 20 is 0x57
        pulse_start();
        check("start_in_ready", 32'(in_ready), 32'd1);
        send_nominal_payload();
        check("last_we", 32'(imem_we), 32'd1);
        check("last_addr", imem_addr, 32'h4);
        check("last_data", imem_wdata, 32'h01095020);
        check("loading_cpu_reset", 32'(cpu_reset), 32'd1);
        send(8'h57);
        in_valid = 1'b0;
        check("nom_done", 32'(done), 32'd1);
        check("nom_cpu_reset", 32'(cpu_reset), 32'd0);
        check("nom_error", 32'(error), 32'd0);
        check("nom_writes", 32'(log_q.size()), 32'd2);
        check("nom_w0_addr", log_q[0].a, 32'h0);
        check("nom_w0_data", log_q[0].d, 32'h20080005);
        check("nom_w1_addr", log_q[1].a, 32'h4);
        check("nom_w1_data", log_q[1].d, 32'h01095020);
        check("nom_spacing", 32'(log_q[1].c - log_q[0].c), 32'd4);

        noise(6);
        check("done_no_consume", 32'(log_q.size()), 32'd2);
        check("done_sticky", 32'(done), 32'd1);
        check("done_in_ready", 32'(in_ready), 32'd0);

        pulse_start();
        check("restart_cpu_reset", 32'(cpu_reset), 32'd1);
        check("restart_done_clr", 32'(done), 32'd0);
        send_nominal_payload();
        send(8'h5E);
        in_valid = 1'b0;
        check("bad_error", 32'(error), 32'd1);
        check("bad_done", 32'(done), 32'd0);
        check("bad_cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad_writes", 32'(log_q.size()), 32'd4);
        check("bad_w3_data", log_q[3].d, 32'h01095020);
        tick();
        check("bad_sticky", 32'(error), 32'd1);

        pulse_start();
        check("err_restart_ready", 32'(in_ready), 32'd1);
        check("err_restart_clr", 32'(error), 32'd0);
        send(8'h01); send(8'h01);
        in_valid = 1'b0;
        check("len_big_error", 32'(error), 32'd1);
        check("len_big_ready", 32'(in_ready), 32'd0);
        tick(); tick();
        check("len_big_no_write", 32'(log_q.size()), 32'd4);

        pulse_start();
        send(8'h00); send(8'h00); send(8'h00);
        in_valid = 1'b0;
        check("len0_done", 32'(done), 32'd1);
        check("len0_cpu_reset", 32'(cpu_reset), 32'd0);
        check("len0_no_write", 32'(log_q.size()), 32'd4);

        pulse_start();
        send(8'h00); send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_kept_write", 32'(log_q.size()), 32'd5);
        check("midrst_w4_data", log_q[4].d, 32'h11223344);
        reset = 1'b0;
        tick();

        // Fresh load with a start pulse during DATA; XOR of 00 02 AA BB CC DD 01 02 03 04 is 0x06
        pulse_start();
        send(8'h00); send(8'h02); send(8'hAA); send(8'hBB);
        start = 1'b1;
        send(8'hCC);
        start = 1'b0;
        send(8'hDD); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h06);
        in_valid = 1'b0;
        check("fresh_done", 32'(done), 32'd1);
        check("fresh_writes", 32'(log_q.size()), 32'd7);
        check("fresh_w0_addr", log_q[5].a, 32'h0);
        check("fresh_w0_data", log_q[5].d, 32'hAABBCCDD);
        check("fresh_w1_addr", log_q[6].a, 32'h4);
        check("fresh_w1_data", log_q[6].d, 32'h01020304);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
